// File: rtl/store_buffer_be_pkg.sv
// Shared store-path definitions: byte-enable op encodings (also used by load extension)
// and the default DM / timer / interrupt-generator address map.
package store_buffer_be_pkg;

    typedef enum logic [2:0] {
        BE_NONE     = 3'd0,
        BE_word     = 3'd1,
        BE_halfword = 3'd2,
        BE_byte     = 3'd3
    } be_op_e;

    localparam logic [31:0] DM_END_DEF  = 32'h0000_2fff;
    localparam logic [31:0] T0_BASE_DEF = 32'h0000_7f00;
    localparam logic [31:0] T1_BASE_DEF = 32'h0000_7f10;
    localparam logic [31:0] IG_BASE_DEF = 32'h0000_7f20;

    // Timer window is 12 bytes; the count register occupies the last word.
    localparam logic [31:0] TMR_LAST_OFS = 32'd11;
    localparam logic [31:0] TMR_CNT_OFS  = 32'd8;
    localparam logic [31:0] IG_LAST_OFS  = 32'd3;

    function automatic logic addr_in(input logic [31:0] a,
                                     input logic [31:0] first,
                                     input logic [31:0] last);
        return (a >= first) && (a <= last);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store decode: address exception checks, lane shift of data and byte-enable mask.
module store_lane_align
    import store_buffer_be_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] DM_END  = DM_END_DEF,
    parameter logic [31:0] T0_BASE = T0_BASE_DEF,
    parameter logic [31:0] T1_BASE = T1_BASE_DEF,
    parameter logic [31:0] IG_BASE = IG_BASE_DEF
) (
    input  logic [2:0]          op_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    input  logic                ovf_i,
    output logic                is_st_o,
    output logic                addr_exc_o,
    output logic                is_dm_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] byteen_o
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);

    logic              is_word, is_half, is_byte;
    logic              misalign, in_dm, in_t0, in_t1, in_ig, in_timer, in_cnt, out_of_range;
    logic [LB-1:0]     off;
    logic [DATA_W-1:0] wdata_base;
    logic [LANES-1:0]  byteen_base;

    assign is_word = (op_i == BE_word);
    assign is_half = (op_i == BE_halfword);
    assign is_byte = (op_i == BE_byte);
    assign is_st_o = is_word || is_half || is_byte;

    assign misalign = (is_word && (addr_i[1:0] != 2'b00)) || (is_half && addr_i[0]);

    assign in_dm    = (addr_i <= DM_END);
    assign in_t0    = addr_in(addr_i, T0_BASE, T0_BASE + TMR_LAST_OFS);
    assign in_t1    = addr_in(addr_i, T1_BASE, T1_BASE + TMR_LAST_OFS);
    assign in_ig    = addr_in(addr_i, IG_BASE, IG_BASE + IG_LAST_OFS);
    assign in_timer = in_t0 || in_t1;
    assign in_cnt   = addr_in(addr_i, T0_BASE + TMR_CNT_OFS, T0_BASE + TMR_LAST_OFS)
                   || addr_in(addr_i, T1_BASE + TMR_CNT_OFS, T1_BASE + TMR_LAST_OFS);
    assign out_of_range = !(in_dm || in_timer || in_ig);

    // Timer registers accept only full-word writes, and the count register is read-only.
    assign addr_exc_o = ovf_i || misalign || out_of_range || (in_timer && !is_word) || in_cnt;
    assign is_dm_o    = in_dm;

    assign off = addr_i[LB-1:0];

    always_comb begin
        wdata_base  = '0;
        byteen_base = '0;
        if (is_word) begin
            wdata_base[31:0] = data_i;
            byteen_base[3:0] = 4'b1111;
        end else if (is_half) begin
            wdata_base[15:0] = data_i[15:0];
            byteen_base[1:0] = 2'b11;
        end else if (is_byte) begin
            wdata_base[7:0] = data_i[7:0];
            byteen_base[0]  = 1'b1;
        end
    end

    assign wdata_o  = wdata_base << {off, 3'b000};
    assign byteen_o = byteen_base << off;

endmodule

// File: rtl/store_buffer_be.sv
// M-stage store buffer: AdES check, lane alignment, DEPTH-entry FIFO with optional same-word
// DM merge, valid/ready drain to the bus, and load-hazard detection against queued words.
module store_buffer_be
    import store_buffer_be_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter int          MERGE_EN = 1,
    parameter logic [31:0] DM_END   = DM_END_DEF,
    parameter logic [31:0] T0_BASE  = T0_BASE_DEF,
    parameter logic [31:0] T1_BASE  = T1_BASE_DEF,
    parameter logic [31:0] IG_BASE  = IG_BASE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                st_valid,
    input  logic [2:0]          st_op,
    input  logic [31:0]         st_addr,
    input  logic [31:0]         st_data,
    input  logic                st_ovf,
    input  logic                req,
    output logic                st_ready,
    output logic                exc_ades,
    input  logic                ld_valid,
    input  logic [31:0]         ld_addr,
    output logic                ld_hazard,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [31:0]         bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_byteen,
    output logic                empty
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int PW    = $clog2(DEPTH);
    localparam int WA_W  = 32 - LB;

    logic [WA_W-1:0]   ent_wa_q    [DEPTH];
    logic [DATA_W-1:0] ent_wdata_q [DEPTH];
    logic [LANES-1:0]  ent_be_q    [DEPTH];

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_ptr;
    logic [PW:0]      count_q, count_d;

    logic              in_is_st, in_exc, in_is_dm;
    logic [DATA_W-1:0] in_wdata, mrg_wdata;
    logic [LANES-1:0]  in_be;
    logic [WA_W-1:0]   in_wa;
    logic              push, pop, do_merge, do_alloc, ld_hit;
    logic              unused_ld_lsb;

    store_lane_align #(
        .DATA_W  (DATA_W),
        .DM_END  (DM_END),
        .T0_BASE (T0_BASE),
        .T1_BASE (T1_BASE),
        .IG_BASE (IG_BASE)
    ) u_align (
        .op_i       (st_op),
        .addr_i     (st_addr),
        .data_i     (st_data),
        .ovf_i      (st_ovf),
        .is_st_o    (in_is_st),
        .addr_exc_o (in_exc),
        .is_dm_o    (in_is_dm),
        .wdata_o    (in_wdata),
        .byteen_o   (in_be)
    );

    assign in_wa    = st_addr[31:LB];
    assign tail_ptr = wr_ptr_q - 1'b1;

    assign st_ready  = (count_q != (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign exc_ades  = st_valid && in_is_st && in_exc;
    assign push      = st_valid && in_is_st && st_ready && !in_exc && !req;

    // Bus side is fed only from registered entries, gated to zero when the head is idle.
    assign bus_valid  = vld_q[rd_ptr_q];
    assign bus_addr   = bus_valid ? {ent_wa_q[rd_ptr_q], {LB{1'b0}}} : '0;
    assign bus_wdata  = bus_valid ? ent_wdata_q[rd_ptr_q] : '0;
    assign bus_byteen = bus_valid ? ent_be_q[rd_ptr_q] : '0;
    assign pop        = bus_valid && bus_ready;

    // The tail is the head only when one entry remains; never merge into a leaving entry.
    assign do_merge = (MERGE_EN != 0) && push && (count_q != '0) && in_is_dm
                   && (ent_wa_q[tail_ptr] == in_wa) && !(pop && (rd_ptr_q == tail_ptr));
    assign do_alloc = push && !do_merge;

    always_comb begin
        mrg_wdata = ent_wdata_q[tail_ptr];
        for (int l = 0; l < LANES; l++) begin
            if (in_be[l]) mrg_wdata[8*l +: 8] = in_wdata[8*l +: 8];
        end
    end

    always_comb begin
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (do_alloc) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        case ({do_alloc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ent_wa_q[wr_ptr_q]    <= in_wa;
            ent_wdata_q[wr_ptr_q] <= in_wdata;
            ent_be_q[wr_ptr_q]    <= in_be;
        end else if (do_merge) begin
            ent_wdata_q[tail_ptr] <= mrg_wdata;
            ent_be_q[tail_ptr]    <= ent_be_q[tail_ptr] | in_be;
        end
    end

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ent_wa_q[i] == ld_addr[31:LB])) ld_hit = 1'b1;
        end
    end

    assign ld_hazard     = ld_valid && ld_hit;
    assign unused_ld_lsb = ^ld_addr[LB-1:0];

endmodule

// File: tb/tb_store_buffer_be.sv
// Directed bench for store_buffer_be (DATA_W=32, DEPTH=4, MERGE_EN=1) with hand-computed expectations.
module tb_store_buffer_be;
    import store_buffer_be_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [2:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ovf;
    logic        req;
    logic        st_ready;
    logic        exc_ades;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        empty;

    int n_total = 0;
    int n_pass  = 0;

    store_buffer_be dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ovf     (st_ovf),
        .req        (req),
        .st_ready   (st_ready),
        .exc_ades   (exc_ades),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hazard  (ld_hazard),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic ovf);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
        st_ovf   = ovf;
    endtask

    task automatic idle_st();
        st_valid = 1'b0;
        st_op    = BE_NONE;
        st_ovf   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  bad_op   [8];
        logic [31:0] bad_addr [8];
        logic        bad_ovf  [8];
        logic        bad_exc  [8];
        logic [31:0] fifo_a   [5];

        reset = 1'b1; st_valid = 1'b0; st_op = BE_NONE; st_addr = '0; st_data = '0;
        st_ovf = 1'b0; req = 1'b0; ld_valid = 1'b0; ld_addr = '0; bus_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_byteen", bus_byteen, 4'b0000);
        chk("rst_empty", empty, 1'b1);
        chk("rst_st_ready", st_ready, 1'b1);

        // 1: word store, latency one, popped immediately
        bus_ready = 1'b1;
        set_st(BE_word, 32'h0100, 32'h1122_3344, 1'b0);
        #1;
        chk("t1_exc", exc_ades, 1'b0);
        step();
        idle_st();
        #1;
        chk("t1_valid", bus_valid, 1'b1);
        chk("t1_addr", bus_addr, 32'h0100);
        chk("t1_byteen", bus_byteen, 4'b1111);
        chk("t1_wdata", bus_wdata, 32'h1122_3344);
        step();
        chk("t1_empty", empty, 1'b1);
        chk("t1_valid_off", bus_valid, 1'b0);

        // 2: sb then sh to the same DM word merge into one entry
        bus_ready = 1'b0;
        set_st(BE_byte, 32'h0103, 32'h0000_00AB, 1'b0);
        step();
        set_st(BE_halfword, 32'h0100, 32'h0000_CDEF, 1'b0);
        step();
        idle_st();
        #1;
        chk("t2_addr", bus_addr, 32'h0100);
        chk("t2_byteen", bus_byteen, 4'b1011);
        chk("t2_wdata", bus_wdata, 32'hAB00_CDEF);
        bus_ready = 1'b1;
        step();
        chk("t2_single_entry", empty, 1'b1);

        // 3: address exceptions never push; an unknown op is not a store
        bad_op[0] = BE_halfword; bad_addr[0] = 32'h7f02; bad_ovf[0] = 1'b0; bad_exc[0] = 1'b1;
        bad_op[1] = BE_word;     bad_addr[1] = 32'h7f08; bad_ovf[1] = 1'b0; bad_exc[1] = 1'b1;
        bad_op[2] = BE_word;     bad_addr[2] = 32'h3000; bad_ovf[2] = 1'b0; bad_exc[2] = 1'b1;
        bad_op[3] = BE_word;     bad_addr[3] = 32'h0102; bad_ovf[3] = 1'b0; bad_exc[3] = 1'b1;
        bad_op[4] = BE_word;     bad_addr[4] = 32'h0100; bad_ovf[4] = 1'b1; bad_exc[4] = 1'b1;
        bad_op[5] = BE_word;     bad_addr[5] = 32'h7f1c; bad_ovf[5] = 1'b0; bad_exc[5] = 1'b1;
        bad_op[6] = BE_word;     bad_addr[6] = 32'h7f18; bad_ovf[6] = 1'b0; bad_exc[6] = 1'b1;
        bad_op[7] = 3'd7;        bad_addr[7] = 32'h0102; bad_ovf[7] = 1'b0; bad_exc[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_st(bad_op[i], bad_addr[i], 32'hDEAD_BEEF, bad_ovf[i]);
            #1;
            chk($sformatf("t3_exc_%0d", i), exc_ades, bad_exc[i]);
            step();
            chk($sformatf("t3_nopush_%0d", i), empty, 1'b1);
        end
        set_st(BE_word, 32'h2ffc, 32'h0BAD_F00D, 1'b0);
        #1;
        chk("t3_dm_last_exc", exc_ades, 1'b0);
        step();
        idle_st();
        #1;
        chk("t3_dm_last_addr", bus_addr, 32'h2ffc);
        step();
        chk("t3_dm_last_drained", empty, 1'b1);

        // timer stores to the same word stay separate entries
        bus_ready = 1'b0;
        set_st(BE_word, 32'h7f04, 32'h1, 1'b0);
        step();
        set_st(BE_word, 32'h7f04, 32'h2, 1'b0);
        #1;
        chk("tmr_exc", exc_ades, 1'b0);
        step();
        idle_st();
        #1;
        chk("tmr_first", bus_wdata, 32'h1);
        bus_ready = 1'b1;
        step();
        chk("tmr_second_valid", bus_valid, 1'b1);
        chk("tmr_second", bus_wdata, 32'h2);
        step();
        chk("tmr_empty", empty, 1'b1);

        // 4: fill to DEPTH, hold the fifth, then drain in order
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_a[i] = 32'h0200 + 32'(4 * i);
        for (int i = 0; i < 4; i++) begin
            set_st(BE_word, fifo_a[i], 32'hA0 + 32'(i), 1'b0);
            #1;
            chk($sformatf("t4_ready_%0d", i), st_ready, 1'b1);
            step();
        end
        set_st(BE_word, fifo_a[4], 32'hA4, 1'b0);
        #1;
        chk("t4_full_ready", st_ready, 1'b0);
        step();
        chk("t4_full_hold", st_ready, 1'b0);
        chk("t4_head0", bus_addr, fifo_a[0]);
        bus_ready = 1'b1;
        #1;
        chk("t4_no_bypass", st_ready, 1'b0);
        step();
        chk("t4_ready_after_pop", st_ready, 1'b1);
        for (int k = 1; k < 5; k++) begin
            if (k == 2) idle_st();
            #1;
            chk($sformatf("t4_valid_%0d", k), bus_valid, 1'b1);
            chk($sformatf("t4_addr_%0d", k), bus_addr, fifo_a[k]);
            chk($sformatf("t4_data_%0d", k), bus_wdata, 32'hA0 + 32'(k));
            step();
        end
        chk("t4_empty", empty, 1'b1);

        // 5: load hazard against a queued word
        bus_ready = 1'b0;
        set_st(BE_word, 32'h0104, 32'h5555_5555, 1'b0);
        step();
        idle_st();
        ld_valid = 1'b1; ld_addr = 32'h0106;
        #1;
        chk("t5_hit", ld_hazard, 1'b1);
        ld_addr = 32'h0108;
        #1;
        chk("t5_miss", ld_hazard, 1'b0);
        ld_valid = 1'b0; ld_addr = 32'h0104;
        #1;
        chk("t5_no_load", ld_hazard, 1'b0);
        bus_ready = 1'b1;
        step();
        chk("t5_drained", empty, 1'b1);

        // 6: req blocks the enqueue; reset mid-drain discards entries
        bus_ready = 1'b0;
        set_st(BE_word, 32'h0300, 32'h1234_5678, 1'b0);
        req = 1'b1;
        #1;
        chk("t6_req_exc", exc_ades, 1'b0);
        step();
        req = 1'b0;
        idle_st();
        #1;
        chk("t6_req_nopush", empty, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_st(BE_word, 32'h0300 + 32'(4 * i), 32'h77 + 32'(i), 1'b0);
            step();
        end
        idle_st();
        bus_ready = 1'b1;
        step();
        chk("t6_draining", bus_addr, 32'h0304);
        reset = 1'b1;
        step();
        chk("t6_rst_valid", bus_valid, 1'b0);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_byteen", bus_byteen, 4'b0000);
        chk("t6_rst_ready", st_ready, 1'b1);
        reset = 1'b0;

        // byte store on lane 1 after reset
        set_st(BE_byte, 32'h0401, 32'hFFFF_FF5A, 1'b0);
        step();
        idle_st();
        #1;
        chk("t7_byteen", bus_byteen, 4'b0010);
        chk("t7_wdata", bus_wdata, 32'h0000_5A00);
        chk("t7_addr", bus_addr, 32'h0400);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
